// File: rtl/tiles_pkg.sv
// tiles_pkg
// Shared definitions for the tile game blocks.
//   DEF_LANES : default lane count, which is also the width of the generator's state bus
//   state_e   : top-level game FSM states (IDLE / PLAY / OVER)
//   is_onehot : 1 when exactly one bit is set. X or Z inputs make it return X,
//               and an if/else on that result falls to the "not one-hot" branch.
package tiles_pkg;

   localparam int DEF_LANES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_e;

   function automatic logic is_onehot(input logic [DEF_LANES-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/tile_judge_if.sv
// tile_judge_if
// Groups the game-side signals of tile_judge.
//   state/state_change : new row from the lane generator
//   btn/start          : player inputs (single-cycle pulses)
//   grid/score         : visible rows (row r at grid[r*LANES +: LANES]) and the hit count
//   playing/game_over  : game status levels
//   hit/miss           : one-cycle event pulses
// The master modport drives the inputs; tile_judge uses the slave modport.
interface tile_judge_if
   import tiles_pkg::*;
#(
   parameter int ROWS    = 4,
   parameter int LANES   = DEF_LANES,
   parameter int SCORE_W = 8
);
   logic [LANES-1:0]      state;
   logic                  state_change;
   logic [LANES-1:0]      btn;
   logic                  start;
   logic [ROWS*LANES-1:0] grid;
   logic [SCORE_W-1:0]    score;
   logic                  playing;
   logic                  game_over;
   logic                  hit;
   logic                  miss;

   modport master (
      output state, state_change, btn, start,
      input  grid, score, playing, game_over, hit, miss
   );

   modport slave (
      input  state, state_change, btn, start,
      output grid, score, playing, game_over, hit, miss
   );
endinterface

// File: rtl/tile_row_buffer.sv
// tile_row_buffer
// ROWS x LANES shift register that holds the falling tiles. Row 0 is the top row
// and row ROWS-1 is the bottom row.
//   clk, rst     : clock, synchronous active-high reset
//   i_shift      : advance one row; row 0 loads i_new_row
//   i_new_row    : row entering at the top
//   i_clr_bottom : clear the bottom row (press hit). A shift in the same cycle overrides it.
//   i_clear      : synchronous clear of the whole buffer
//   o_grid       : all rows packed, row r at [r*LANES +: LANES]
//   o_exit_row   : the row that a shift would push out, after any same-cycle bottom clear
module tile_row_buffer #(
   parameter int ROWS  = 4,
   parameter int LANES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_shift,
   input  logic [LANES-1:0]      i_new_row,
   input  logic                  i_clr_bottom,
   input  logic                  i_clear,
   output logic [ROWS*LANES-1:0] o_grid,
   output logic [LANES-1:0]      o_exit_row
);

   logic [LANES-1:0] w_rows [ROWS];

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_row
         localparam bit IS_BOTTOM = (gi == ROWS - 1);
         logic [LANES-1:0] r_row;
         logic [LANES-1:0] w_src;

         if (gi == 0) begin : g_top
            assign w_src = i_new_row;
         end else begin : g_inner
            assign w_src = w_rows[gi-1];
         end

         always_ff @(posedge clk) begin
            if (rst || i_clear) begin
               r_row <= '0;
            end else if (i_shift) begin
               r_row <= w_src;
            end else if (IS_BOTTOM && i_clr_bottom) begin
               r_row <= '0;
            end
         end

         assign w_rows[gi]                 = r_row;
         assign o_grid[gi*LANES +: LANES]  = r_row;
      end
   endgenerate

   // A hit clears the bottom tile before it can leave, so it never counts as missed.
   assign o_exit_row = i_clr_bottom ? '0 : w_rows[ROWS-1];

endmodule

// File: rtl/tile_judge.sv
// tile_judge
// Holds the falling tile rows and judges player presses against the bottom row.
// It also keeps a saturating score and runs the IDLE/PLAY/OVER game FSM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tile_judge_if.slave (state, state_change, btn, start in;
//              grid, score, playing, game_over, hit, miss out)
// All outputs are registered, so they show the inputs sampled one edge earlier.
module tile_judge
   import tiles_pkg::*;
#(
   parameter int ROWS    = 4,
   parameter int LANES   = DEF_LANES,
   parameter int SCORE_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   tile_judge_if.slave  bus
);

   state_e                r_state;
   logic [SCORE_W-1:0]    r_score;
   logic                  r_playing;
   logic                  r_game_over;
   logic                  r_hit;
   logic                  r_miss;

   logic [ROWS*LANES-1:0] w_grid;
   logic [LANES-1:0]      w_bottom;
   logic [LANES-1:0]      w_exit_row;
   logic [LANES-1:0]      w_new_row;
   logic                  w_in_play;
   logic                  w_press;
   logic                  w_hit;
   logic                  w_wrong;
   logic                  w_shift;
   logic                  w_exit_miss;
   logic                  w_clear;

   assign w_bottom  = w_grid[(ROWS-1)*LANES +: LANES];
   assign w_in_play = (r_state == ST_PLAY);

   // A row that is not exactly one-hot (including X after generator power-up)
   // enters as an empty row. The if/else sends an X result to the empty case.
   always_comb begin
      w_new_row = '0;
      if (is_onehot(bus.state)) begin
         w_new_row = bus.state;
      end
   end

   // The press is judged first. Any press other than an exact single-lane match
   // on a non-empty bottom row ends the game and blocks that cycle's shift.
   assign w_press     = |bus.btn;
   assign w_hit       = w_in_play && w_press && (bus.btn == w_bottom) && (w_bottom != '0);
   assign w_wrong     = w_in_play && w_press && !w_hit;
   assign w_shift     = w_in_play && bus.state_change && !w_wrong;
   assign w_exit_miss = w_shift && (w_exit_row != '0);
   assign w_clear     = bus.start && !w_in_play;

   tile_row_buffer #(
      .ROWS  (ROWS),
      .LANES (LANES)
   ) u_rows (
      .clk          (clk),
      .rst          (rst),
      .i_shift      (w_shift),
      .i_new_row    (w_new_row),
      .i_clr_bottom (w_hit),
      .i_clear      (w_clear),
      .o_grid       (w_grid),
      .o_exit_row   (w_exit_row)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_score     <= '0;
         r_playing   <= 1'b0;
         r_game_over <= 1'b0;
         r_hit       <= 1'b0;
         r_miss      <= 1'b0;
      end else begin
         r_hit  <= 1'b0;
         r_miss <= 1'b0;
         case (r_state)
            ST_IDLE, ST_OVER: begin
               if (bus.start) begin
                  r_state     <= ST_PLAY;
                  r_score     <= '0;
                  r_playing   <= 1'b1;
                  r_game_over <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (w_hit) begin
                  r_hit <= 1'b1;
                  if (r_score != '1) begin
                     r_score <= r_score + 1'b1;
                  end
               end
               if (w_wrong || w_exit_miss) begin
                  r_state     <= ST_OVER;
                  r_playing   <= 1'b0;
                  r_game_over <= 1'b1;
                  r_miss      <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_playing   <= 1'b0;
               r_game_over <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grid      = w_grid;
   assign bus.score     = r_score;
   assign bus.playing   = r_playing;
   assign bus.game_over = r_game_over;
   assign bus.hit       = r_hit;
   assign bus.miss      = r_miss;

endmodule

// File: doc/tile_judge.md
# tile_judge

Downstream consumer of the lane generator's one-hot `state` / `state_change` output. Holds the falling tile rows in a shift buffer and advances the buffer one row per `state_change`. Judges player button presses against the bottom row and keeps a saturating score. Drives the game-over condition to the display and score logic.

## Interface
Parameters:
- `ROWS`, 4: visible tile rows; row 0 is top, row `ROWS-1` is the bottom (target) row.
- `LANES`, 4: lanes per row; must equal the width of `state`.
- `SCORE_W`, 8: score counter width.

Ports:
- `clk` in 1: single system clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `state` in `LANES`: one-hot lane of the newest tile from the generator.
- `state_change` in 1: one-cycle pulse; new row available on `state`.
- `btn` in `LANES`: debounced, single-cycle press pulses, synchronous to `clk`.
- `start` in 1: single-cycle pulse; begin a new game.
- `grid` out `ROWS*LANES`: row r at `grid[r*LANES +: LANES]`.
- `score` out `SCORE_W`: hits this game, saturating.
- `playing` out 1: high in PLAY.
- `game_over` out 1: high in OVER.
- `hit` out 1: one-cycle pulse per correct press.
- `miss` out 1: one-cycle pulse on the game-ending event.

## Operation
- FSM states: IDLE, PLAY, OVER. Reset enters IDLE. In IDLE, `grid`=0, `score`=0 and all flags are 0.
- IDLE or OVER, `start`=1: enter PLAY, clear `grid` and `score`. Any `btn`/`state_change` in that same cycle is ignored.
- IDLE: `state_change` and `btn` are ignored.
- PLAY, press judgement (`btn`≠0), done first, against the current bottom row B:
  - `btn`==B and B≠0: hit. Clear B to 0, `score`+1 (holds at all-ones), pulse `hit`.
  - Otherwise: wrong press. Covers B=0, a lane mismatch, or multiple `btn` bits set. Go to OVER, pulse `miss`, suppress any shift in that cycle.
- PLAY, shift (`state_change`=1, no wrong press in the same cycle):
  - Row r takes row r-1, and row 0 takes `state`.
  - A `state` value that is not one-hot (zero, multi-bit, or X after generator power-up) loads as an empty row.
  - If the exiting bottom row is nonzero after any same-cycle hit clear, the tile was missed: go to OVER, pulse `miss`. The shift still completes, so the grid shows the advanced rows.
- Simultaneous hit and `state_change`: the bottom row is cleared first, then the shift runs, so no miss is raised.
- OVER: `grid` and `score` freeze. `game_over`=1. `btn` and `state_change` are ignored.
- `rst` mid-game: returns to IDLE next edge and clears everything. Pending pulses are dropped.

## Timing
- All outputs are registered. They reflect inputs sampled at edge N from after edge N, so latency is 1 cycle.
- `hit` and `miss` are high for exactly one cycle. `miss` and the rise of `game_over` coincide.
- `playing` and `game_over` change the cycle after the causing `start`, wrong press or exit.
- No handshake back to the generator: every `state_change` pulse is consumed in its own cycle.
- Back-to-back `state_change` on consecutive cycles each shift once.

## Structure
- Shared package `tiles_pkg` holds:
  - `LANES` default;
  - FSM state enum (IDLE/PLAY/OVER);
  - function `is_onehot(logic [LANES-1:0])`, also reusable by the generator checker.
- Natural sub-module: `tile_row_buffer`, the `ROWS`×`LANES` shift register. Its inputs are shift enable, new row, bottom-clear and sync clear; its outputs are the grid and the exiting row.
- FSM, judge and score logic stay in `tile_judge`.

## Test plan
- Reset, then `start`: `grid`=0, `score`=0, `playing`=1 next cycle. `state_change` during IDLE leaves `grid`=0.
- PLAY, four shifts with `state` 1000, 0100, 0010, 0001:
  - bottom row = 1000;
  - `btn`=1000 → `hit` pulse, `score`=1, bottom row 0;
  - next shift → no miss.
- Bottom row 0100 and `btn`=0010 → `miss` pulse, `game_over`=1, later `state_change`/`btn` leave `grid` and `score` unchanged.
- Bottom row 0001 left unpressed, `state_change` → `miss`, `game_over`=1, grid shows the shifted rows.
- Same-cycle `btn`=bottom lane and `state_change` → `hit`, no `miss`, `score`+1. With `SCORE_W`=2 and 5 hits, `score` holds at 3.
- `state`=0110 or 0000 on shift loads an empty row. `rst` asserted mid-PLAY → IDLE, `score`=0, `grid`=0 next cycle.
